// File: rtl/barcode_pkg.sv
// Shared definitions for the 2-of-5 barcode link: FSM states, frame marker,
// code table and frame width.
package barcode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int          FRAME_W      = 8;
    localparam logic [2:0]  START_MARKER = 3'b101;

    // Entry n is the code for digit n; weights (1,2,4,7,0) on bits 4..0.
    localparam logic [9:0][4:0] CODE_TABLE = {
        5'b01010,   // 9
        5'b10010,   // 8
        5'b00011,   // 7
        5'b01100,   // 6
        5'b10100,   // 5
        5'b00101,   // 4
        5'b11000,   // 3
        5'b01001,   // 2
        5'b10001,   // 1
        5'b00110    // 0
    };

endpackage

// File: rtl/enc_2of5.sv
// Combinational BCD digit to 2-of-5 code; valid flags digits 0..9,
// code is all-zero otherwise.
module enc_2of5
    import barcode_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [4:0] o_code,
    output logic       o_valid
);

    logic w_valid;

    assign w_valid = (i_digit <= 4'd9);
    assign o_valid = w_valid;
    assign o_code  = w_valid ? CODE_TABLE[i_digit] : 5'b00000;

endmodule

// File: rtl/barcode_2of5_tx.sv
// 2-of-5 barcode transmitter: one digit per handshake, parallel frame plus
// timed serial bar stream. Build macro: BARCODE_TX_INVALID_CHECK_EN.
module barcode_2of5_tx
    import barcode_pkg::*;
#(
    parameter int BIT_TICKS = 4,
    parameter int GAP_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         in_digit,
    output logic               in_ready,
    output logic               bar_out,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_active,
    output logic               done,
    output logic               err
);

    localparam int TICK_W = $clog2(BIT_TICKS) + 1;
    localparam int GAP_W  = $clog2(GAP_TICKS) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    state_t              r_state;
    logic [2:0]          r_bit_idx;
    logic [TICK_W-1:0]   r_tick;
    logic [GAP_W-1:0]    r_gap;
    logic                r_ready;
    logic                r_bar;
    logic [FRAME_W-1:0]  r_frame;
    logic                r_active;
    logic                r_done;
    logic                r_err;

    logic [4:0]          w_code;
    logic                w_valid;
    logic                w_take;
    logic                w_reject;
    logic [FRAME_W-1:0]  w_new_frame;
    logic                w_tick_wrap;
    logic [2:0]          w_nxt_idx;
    logic [TICK_W-1:0]   w_nxt_tick;

    enc_2of5 u_enc (
        .i_digit (in_digit),
        .o_code  (w_code),
        .o_valid (w_valid)
    );

`ifdef BARCODE_TX_INVALID_CHECK_EN
    assign w_take   = in_valid &  w_valid;
    assign w_reject = in_valid & ~w_valid;
`else
    // Out-of-range digits go out as a bare marker (encoder returns 5'b0).
    assign w_take   = in_valid;
    assign w_reject = 1'b0;
`endif

    assign w_new_frame = {START_MARKER, w_valid ? w_code : 5'b00000};
    assign w_tick_wrap = (r_tick == TICK_LAST);
    assign w_nxt_idx   = w_tick_wrap ? r_bit_idx + 3'd1 : r_bit_idx;
    assign w_nxt_tick  = w_tick_wrap ? '0 : r_tick + TICK_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_tick    <= '0;
            r_gap     <= '0;
            r_ready   <= 1'b1;
            r_bar     <= 1'b0;
            r_frame   <= '0;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_frame   <= w_new_frame;
                        r_bit_idx <= '0;
                        r_tick    <= '0;
                        r_bar     <= w_new_frame[FRAME_W-1];
                        r_active  <= 1'b1;
                        r_ready   <= 1'b0;
                        r_state   <= SEND;
                    end else if (w_reject) begin
                        r_err <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_tick_wrap && (r_bit_idx == 3'd7)) begin
                        r_gap    <= GAP_LAST;
                        r_bar    <= 1'b0;
                        r_active <= 1'b0;
                        r_state  <= GAP;
                    end else begin
                        r_bit_idx <= w_nxt_idx;
                        r_tick    <= w_nxt_tick;
                        r_bar     <= r_frame[3'd7 - w_nxt_idx];
                        // done is registered, so raise it when entering the final tick
                        r_done    <= (w_nxt_idx == 3'd7) && (w_nxt_tick == TICK_LAST);
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_ready  <= 1'b1;
                    r_bar    <= 1'b0;
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_ready;
    assign bar_out      = r_bar;
    assign frame_out    = r_frame;
    assign frame_active = r_active;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: doc/barcode_2of5_tx.md
# barcode_2of5_tx

Transmitter side of the 2-out-of-5 barcode link: accepts one decimal digit per handshake and emits it as an 8-bit barcode frame, both as a held parallel word (E7..E0 order, directly consumable by the barcode identifier) and as a timed serial bar stream for a single LED or bar driver. It sits upstream of the identifier and serves as the team's stimulus source and loop-back generator.

## Interface
- `BIT_TICKS`, default 4: clock cycles each bar bit is held; must be ≥1.
- `GAP_TICKS`, default 8: quiet cycles (bar low) after each frame; must be ≥1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: digit offered.
- `in_digit` in 4: BCD digit.
- `in_ready` out 1: block can accept a digit.
- `bar_out` out 1: serial bar stream, MSB (E7) first.
- `frame_out` out 8: current frame, bit 7 = E7 … bit 0 = E0.
- `frame_active` out 1: high while a frame's bits are being emitted.
- `done` out 1: one-cycle pulse on the last cycle of the last bit.
- `err` out 1: one-cycle pulse on rejection of an invalid digit.

## Operation
- Frame layout: `[7:5]` start marker 3'b101, `[4:0]` 2-of-5 code with weights (1,2,4,7,0) on bits 4..0.
- Codes: 0=00110, 1=10001, 2=01001, 3=11000, 4=00101, 5=10100, 6=01100, 7=00011, 8=10010, 9=01010.
- States: IDLE, SEND, GAP.
- IDLE: `in_ready`=1 and `bar_out`=0. On `in_valid`:
  - Valid digit: latch the frame into `frame_out`, clear the bit index and tick counter, go to SEND.
  - Digit >9: handled as described under Configuration.
- SEND: `bar_out` = `frame_out[7-bit_idx]`. The tick counter counts 0..BIT_TICKS-1; on wrap, bit_idx increments. After bit_idx 7 wraps, pulse `done` and go to GAP.
- GAP: `bar_out`=0 for GAP_TICKS cycles, then go to IDLE.
- `frame_out` holds its value after the frame until the next accepted digit.
- Inputs are ignored outside IDLE; there is no queuing.
- Every valid frame has exactly four 1 bits: two in the marker and two in the code.

## Timing
- Reset values: state IDLE, `in_ready`=1, `bar_out`=0, `frame_out`=8'h00, `frame_active`=0, `done`=0, `err`=0.
- Accept edge: the rising edge with `in_valid`&`in_ready`. On the next cycle, `frame_active`=1, `in_ready`=0, and `bar_out`=1 (marker bit 7).
- Frame duration is 8·BIT_TICKS cycles. `done` is high on the cycle containing the final bar tick.
- Busy time is 8·BIT_TICKS+GAP_TICKS cycles. `in_ready` returns the cycle after the last gap cycle.
- Back-to-back throughput is one digit per 8·BIT_TICKS+GAP_TICKS+1 cycles.
- `rst` mid-frame: on the next cycle all outputs take their reset values and the partial frame is abandoned.
- Counter widths are `$clog2` of the respective maximum plus one. There is no overflow beyond the parameter range.

## Configuration
- `BARCODE_TX_INVALID_CHECK_EN`:
  - Defined: an `in_valid` digit >9 in IDLE is consumed (`in_ready` stays 1) and `err` pulses for one cycle on the following cycle. No frame is sent and `frame_out` is unchanged.
  - Undefined: `err` is tied to 0, and a digit >9 is sent as the frame 8'b101_00000 (marker, no code bars).

## Structure
- Shared package `barcode_pkg`:
  - state enum (IDLE/SEND/GAP)
  - `START_MARKER` = 3'b101
  - the ten-entry 2-of-5 code table
  - `FRAME_W` = 8
- Sub-module `enc_2of5`: purely combinational digit→5-bit code with a `valid` output (digit ≤9). It is reusable by the identifier's self-test.

## Test plan
- Reset, then idle for 10 cycles: `in_ready`=1, `bar_out`=0, `frame_out`=00, no pulses.
- BIT_TICKS=2, GAP_TICKS=3, digit 0:
  - `frame_out`=8'b10100110.
  - `bar_out` = 11 00 11 00 00 11 11 00, then 000.
  - `done` is high at cycle 16 after accept; `in_ready` is high at cycle 20.
- Digits 0–9 back-to-back with `in_valid` held high: each `frame_out` matches the table, each has popcount 4, and exactly one `done` per digit.
- Digit 4'hC with the macro defined: `err` pulses once, `frame_active` stays 0, and a following digit 7 sends 8'b10100011.
- Digit 4'hC without the macro: `frame_out`=8'b10100000 and `err` stays 0.
- `rst` asserted at cycle 5 of a frame: outputs are at reset values on the next cycle, and a new digit 3 is accepted immediately, sending 8'b10111000.
